// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default width for the arithmetic cells
package arith_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic c_in,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial a+b+c_in using one full adder, LSB first
module serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             carry, fa_s, fa_co, accept, last;
  full_adder u_fa (
    .c_in (carry),
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .s    (fa_s),
    .c_out(fa_co)
  );
  // next state, accept/last-bit decode, and the accumulator with the new sum bit shifted in at the top
  always_comb begin
    accept   = start && state != ST_RUN;
    last     = state == ST_RUN && cnt == CW'(WIDTH - 1);
    state_nx = accept ? ST_RUN : last ? ST_DONE : state == ST_RUN ? ST_RUN : ST_IDLE;
    acc_nx   = acc >> 1;
    acc_nx[WIDTH-1] = fa_s;
  end
  // state register plus operand/carry/accumulator datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= c_in;
        cnt   <= '0;
        acc   <= '0;
      end else if (state == ST_RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        cnt   <= cnt + CW'(1);
        acc   <= acc_nx;
        if (last) begin
          sum   <= acc_nx;
          c_out <= fa_co;
        end
      end
    end
  end
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: model-checked random and directed test of the serial adder
module tb_serial_adder_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       start8 = 0, ci8 = 0, busy8, done8, co8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       start1 = 0, ci1 = 0, busy1, done1, co1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  int checks = 0, errors = 0, ndone8 = 0;
  int left8 = 0, left1 = 0;
  logic [8:0] pend8 = 0, res8 = 0;
  logic [1:0] pend1 = 0, res1 = 0;
  logic mdone8 = 0, mdone1 = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .c_in(ci8), .busy(busy8), .done(done8), .sum(sum8), .c_out(co8));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .c_in(ci1), .busy(busy1), .done(done1), .sum(sum1), .c_out(co1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a request costs WIDTH busy cycles then one done cycle carrying a+b+c_in
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      left8 <= 0; mdone8 <= 0; res8 <= 0; pend8 <= 0;
    end else if (left8 > 0) begin
      left8 <= left8 - 1;
      mdone8 <= (left8 == 1);
      if (left8 == 1) res8 <= pend8;
    end else begin
      mdone8 <= 0;
      if (start8) begin
        pend8 <= 9'(a8) + 9'(b8) + 9'(ci8);
        left8 <= 8;
      end
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      left1 <= 0; mdone1 <= 0; res1 <= 0; pend1 <= 0;
    end else if (left1 > 0) begin
      left1 <= left1 - 1;
      mdone1 <= (left1 == 1);
      if (left1 == 1) res1 <= pend1;
    end else begin
      mdone1 <= 0;
      if (start1) begin
        pend1 <= 2'(a1) + 2'(b1) + 2'(ci1);
        left1 <= 1;
      end
    end

  always @(negedge clk) begin
    chk("busy8", busy8, left8 > 0);
    chk("done8", done8, mdone8);
    chk("sum8", sum8, res8[7:0]);
    chk("cout8", co8, res8[8]);
    chk("excl8", busy8 & done8, 0);
    chk("busy1", busy1, left1 > 0);
    chk("done1", done1, mdone1);
    chk("sum1", sum1, res1[0]);
    chk("cout1", co1, res1[1]);
    if (done8) ndone8++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec, input string name);
    int cyc = 0, bcnt = 0;
    start8 = 1; a8 = a; b8 = b; ci8 = ci;
    tick();
    start8 = 0; a8 = $urandom; b8 = $urandom; ci8 = $urandom;
    while (!done8 && cyc < 40) begin
      if (busy8) bcnt++;
      tick();
      cyc++;
    end
    chk({name, "_lat"}, cyc, 8);
    chk({name, "_busycyc"}, bcnt, 8);
    chk({name, "_sum"}, sum8, es);
    chk({name, "_cout"}, co8, ec);
    tick();
  endtask

  initial begin
    int cyc, d0, t1;
    #2;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", co8, 0);
    tick();
    rst_n = 1;
    tick();
    op8(8'h5A, 8'h3C, 0, 8'h96, 0, "basic");
    op8(8'hFF, 8'h01, 0, 8'h00, 1, "wrap");
    op8(8'hFF, 8'hFF, 1, 8'hFF, 1, "max");
    // start during RUN is ignored
    d0 = ndone8;
    start8 = 1; a8 = 8'h10; b8 = 8'h20; ci8 = 0;
    tick();
    start8 = 0;
    repeat (2) tick();
    start8 = 1; a8 = 8'hAA; b8 = 8'h55;
    tick();
    start8 = 0;
    cyc = 0;
    while (!done8 && cyc < 40) begin tick(); cyc++; end
    chk("ign_sum", sum8, 8'h30);
    chk("ign_cout", co8, 0);
    repeat (12) tick();
    chk("ign_pulses", ndone8 - d0, 1);
    // back-to-back with start held through DONE
    start8 = 1; a8 = 8'h5A; b8 = 8'h3C; ci8 = 0;
    tick();
    a8 = 8'h01; b8 = 8'h02;
    cyc = 0;
    while (!done8 && cyc < 40) begin tick(); cyc++; end
    chk("b2b_sum1", sum8, 8'h96);
    tick();
    start8 = 0;
    t1 = 1;
    while (!done8 && t1 < 40) begin tick(); t1++; end
    chk("b2b_gap", t1, 9);
    chk("b2b_sum2", sum8, 8'h03);
    tick();
    // reset mid-run discards the partial result
    op8(8'h5A, 8'h3C, 0, 8'h96, 0, "pre");
    start8 = 1; a8 = 8'h7F; b8 = 8'h01;
    tick();
    start8 = 0;
    repeat (4) tick();
    rst_n = 0;
    #1;
    chk("mr_busy", busy8, 0);
    chk("mr_done", done8, 0);
    chk("mr_sum", sum8, 0);
    chk("mr_cout", co8, 0);
    tick();
    rst_n = 1;
    d0 = ndone8;
    repeat (20) tick();
    chk("mr_nodone", ndone8 - d0, 0);
    // WIDTH=1 corner
    start1 = 1; a1 = 1; b1 = 1; ci1 = 1;
    tick();
    start1 = 0;
    tick();
    chk("w1_done", done1, 1);
    chk("w1_sum", sum1, 1);
    chk("w1_cout", co1, 1);
    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      start8 = ($urandom % 3) == 0; a8 = $urandom; b8 = $urandom; ci8 = $urandom;
      start1 = ($urandom % 2) == 0; a1 = $urandom; b1 = $urandom; ci1 = $urandom;
      if (i == 300) rst_n = 0;
      if (i == 302) rst_n = 1;
      tick();
    end
    start8 = 0; start1 = 0;
    repeat (12) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
